instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL provide parameter RESET_VECTOR, default 16'h0000, the first fetch address after reset.
REQ-002 The block SHALL provide port CLK  input  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL provide port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL provide port IMEM_REQ  output  1  instruction-memory address request.
REQ-005 The block SHALL provide port IMEM_ADDR  output  16  word address of the request.
REQ-006 The block SHALL provide port IMEM_ACK  input  1  memory accepts the request in this cycle.
REQ-007 The block SHALL provide port IMEM_RVALID  input  1  read data valid for the oldest accepted request.
REQ-008 The block SHALL provide port IMEM_RDATA  input  16  instruction word.
REQ-009 The block SHALL provide port COMMAND  output  16  instruction word presented to the decoder.
REQ-010 The block SHALL provide port PC_OUT  output  16  address of the word on COMMAND.
REQ-011 The block SHALL provide port COMMAND_VALID  output  1  COMMAND/PC_OUT hold a valid entry.
REQ-012 The block SHALL provide port COMMAND_READY  input  1  consumer takes the entry this cycle.
REQ-013 The block SHALL provide port JUMP  input  1  redirect fetch, one-cycle pulse.
REQ-014 The block SHALL provide port JUMP_ADDR  input  16  redirect target, sampled when JUMP=1.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {PC,instruction}, a 16-bit fetch PC (FPC), an outstanding flag (OUT) and FSM state RUN or DISCARD.
REQ-016 The block SHALL count an address transfer when IMEM_REQ=1 and IMEM_ACK=1 in the same cycle; at most one transfer may be outstanding.
REQ-017 The block SHALL drive IMEM_REQ=1 iff state=RUN, OUT=0, FIFO count<2, JUMP=0; IMEM_ADDR=FPC at all times.
REQ-018 The block SHALL, on an address transfer, set OUT=1 and increment FPC by 1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-019 The block SHALL, in RUN with OUT=1 and IMEM_RVALID=1, push {address of that request, IMEM_RDATA} into the FIFO and clear OUT.
REQ-020 The block SHALL ignore IMEM_RVALID when OUT=0.
REQ-021 The block SHALL drive COMMAND/PC_OUT from the FIFO head and COMMAND_VALID=1 iff FIFO non-empty; COMMAND=16'h0000 and PC_OUT=16'h0000 when empty.
REQ-022 The block SHALL pop the head when COMMAND_VALID=1 and COMMAND_READY=1; push and pop in one cycle leave count unchanged, order preserved.
REQ-023 The block SHALL keep COMMAND/PC_OUT stable while COMMAND_VALID=1 and COMMAND_READY=0.
REQ-024 The block SHALL, when JUMP=1: flush the FIFO (ignore any pop that cycle), load FPC=JUMP_ADDR, and go to DISCARD if OUT=1 (after any RVALID that cycle) else stay in RUN.
REQ-025 The block SHALL, in DISCARD, drop the next IMEM_RVALID data, clear OUT and return to RUN; the jump target request issues no earlier than the following cycle.
REQ-026 The block SHALL treat a second JUMP during DISCARD as reloading FPC only, remaining in DISCARD until the stale data returns.
REQ-027 The block SHALL give first-instruction latency of 2 cycles with zero-wait memory (REQ/ACK cycle n, RVALID n+1, COMMAND_VALID n+2).

Reset
REQ-028 The block SHALL, while RST_N=0 (asynchronously): FPC=RESET_VECTOR, FIFO empty, OUT=0, state=RUN, COMMAND_VALID=0, COMMAND=16'h0000, PC_OUT=16'h0000, IMEM_REQ=0.
REQ-029 The block SHALL, on reset assertion mid-transfer, abandon the outstanding request; any RVALID after release with OUT=0 is ignored.
REQ-030 The block SHALL issue the first request (IMEM_ADDR=RESET_VECTOR) in the first cycle after RST_N deasserts.

Verification
REQ-031 Reset release, ACK=1, RVALID one cycle after each transfer, READY=1 -> COMMAND_VALID rises 2 cycles after first REQ, PC_OUT 0,1,2... matching RDATA.
REQ-032 READY=0 with memory streaming -> exactly 2 entries buffered, IMEM_REQ drops, COMMAND/PC_OUT stable; READY=1 -> entries drain in order, fetching resumes.
REQ-033 JUMP to 16'h0040 while a request to 16'h0005 is outstanding -> its data dropped, FIFO flushed, next IMEM_ADDR=16'h0040, next COMMAND PC_OUT=16'h0040.
REQ-034 JUMP_ADDR=16'hFFFF, sequential fetch -> IMEM_ADDR sequence 16'hFFFF, 16'h0000, 16'h0001.
REQ-035 RST_N pulsed low while OUT=1, RVALID arriving after release -> data ignored, first valid COMMAND has PC_OUT=RESET_VECTOR.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one-outstanding memory requester feeding a 2-entry {pc, instr} buffer.
// Redirects flush the buffer and squash the in-flight response via a DISCARD state.

// Generic FIFO with synchronous flush; head is read combinationally.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module if_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rd_en    = pop_rdy && (count != '0);
  assign wr_en    = push_vld && ((count != CW'(DEPTH)) || rd_en);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end
endmodule

// Fetches sequential instruction words and presents them with their PC to the decoder.
// Latency: request in cycle n, data in n+1, command_valid in n+2 with a zero-wait memory.
// Backpressure: fetching stalls once two words are buffered and command_ready stays low.
module instr_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] command,
  output logic [15:0] pc_out,
  output logic        command_valid,
  input  logic        command_ready,
  input  logic        jump,
  input  logic [15:0] jump_addr
);
  typedef enum logic {RUN, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [15:0] fpc, req_pc;
  logic        out;
  logic [1:0]  count;
  logic [31:0] head_dat;
  logic        xfer, take, push, pop;

  assign xfer = imem_req && imem_ack;
  assign take = out && imem_rvalid;
  assign push = take && (state == RUN) && !jump;
  assign pop  = command_valid && command_ready && !jump;

  if_fifo #(.WIDTH(32), .DEPTH(2)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (jump),
    .push_vld (push),
    .push_dat ({req_pc, imem_rdata}),
    .pop_rdy  (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  assign command_valid = (count != 2'd0);
  assign command       = command_valid ? head_dat[15:0]  : 16'h0000;
  assign pc_out        = command_valid ? head_dat[31:16] : 16'h0000;
  assign imem_addr     = fpc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // A redirect with a response still owed must swallow that response before refetching.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (jump && out && !imem_rvalid) state_nxt = DISCARD;
      DISCARD: if (take) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    imem_req = rst_n && (state == RUN) && !out && (count < 2'd2) && !jump;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc    <= RESET_VECTOR;
      out    <= 1'b0;
      req_pc <= 16'h0000;
    end else begin
      if (jump)      fpc <= jump_addr;
      else if (xfer) fpc <= fpc + 16'd1;
      if (xfer) begin
        out    <= 1'b1;
        req_pc <= fpc;
      end else if (take) begin
        out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed scenarios followed by random traffic, checked cycle by cycle against a queue-based model.
module tb_instr_fetch;
  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0, imem_rvalid = 1'b0;
  logic [15:0] imem_addr, imem_rdata = 16'h0000;
  logic [15:0] command, pc_out, jump_addr = 16'h0000;
  logic        command_valid, command_ready = 1'b0, jump = 1'b0;

  instr_fetch #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .command(command), .pc_out(pc_out), .command_valid(command_valid),
    .command_ready(command_ready), .jump(jump), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, first_req = -1, first_vld = -1;

  // reference model state
  logic [15:0] m_fpc = RV, m_oaddr = 16'h0000;
  logic        m_out = 1'b0, m_disc = 1'b0;
  logic [31:0] m_q[$];

  // memory model and logs
  logic        mem_pend = 1'b0;
  logic [15:0] mem_paddr = 16'h0000;
  int          mem_wait = 0, mem_lat = 0;
  logic [15:0] xlog[$];
  logic [31:0] plog[$];
  logic        seq_on = 1'b0;
  logic [15:0] seq = 16'h0000;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[6:0], a[15:7]} ^ 16'hC35A;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic a_rst, input logic a_ack, input logic a_rdy,
                       input logic a_jmp, input logic [15:0] a_jaddr, input logic a_spur);
    logic e_req, e_vld, xf, tk, kp, pp;
    logic [15:0] e_cmd, e_pc;
    rst_n       = a_rst;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'($urandom);
    if (mem_pend) begin
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mdata(mem_paddr);
        mem_pend    = 1'b0;
      end else begin
        mem_wait--;
      end
    end else if (a_spur && a_rst && !m_out) begin
      imem_rvalid = 1'b1;
    end
    imem_ack      = a_ack && !mem_pend;
    command_ready = a_rdy;
    jump          = a_jmp;
    jump_addr     = a_jaddr;
    #1;
    if (!rst_n) begin
      m_fpc = RV; m_out = 1'b0; m_disc = 1'b0; m_q.delete();
    end
    e_req = rst_n && !m_disc && !m_out && (m_q.size() < 2) && !jump;
    e_vld = (m_q.size() != 0);
    e_cmd = e_vld ? m_q[0][15:0]  : 16'h0000;
    e_pc  = e_vld ? m_q[0][31:16] : 16'h0000;
    chk("imem_req", 16'(imem_req), 16'(e_req));
    chk("imem_addr", imem_addr, m_fpc);
    chk("command_valid", 16'(command_valid), 16'(e_vld));
    chk("command", command, e_cmd);
    chk("pc_out", pc_out, e_pc);
    if (rst_n) begin
      if (first_req < 0 && imem_req) first_req = cyc;
      if (first_vld < 0 && command_valid) first_vld = cyc;
      if (imem_req && imem_ack) begin
        mem_pend = 1'b1; mem_paddr = imem_addr; mem_wait = mem_lat;
        xlog.push_back(imem_addr);
      end
      if (command_valid && command_ready && !jump) begin
        plog.push_back({pc_out, command});
        if (seq_on) begin
          chk("seq_pc", pc_out, seq);
          chk("seq_cmd", command, mdata(seq));
          seq = seq + 16'd1;
        end
      end
      xf = e_req && imem_ack;
      tk = m_out && imem_rvalid;
      kp = tk && !m_disc && !jump;
      pp = e_vld && command_ready && !jump;
      if (jump) m_q.delete();
      else begin
        if (pp) void'(m_q.pop_front());
        if (kp) m_q.push_back({m_oaddr, imem_rdata});
      end
      // a redirect leaves a stale response owed whenever one is in flight and not arriving now
      m_disc = jump ? (m_out && !imem_rvalid) : (m_disc && !imem_rvalid);
      if (xf) begin m_out = 1'b1; m_oaddr = m_fpc; end
      else if (tk) m_out = 1'b0;
      if (jump) m_fpc = jump_addr;
      else if (xf) m_fpc = m_fpc + 16'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic        found;
    logic [15:0] stall_pc, stall_cmd;
    @(negedge clk);
    // reset held
    repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);

    // streaming from reset with a zero-wait memory
    first_req = -1; first_vld = -1; seq = RV; seq_on = 1'b1;
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    seq_on = 1'b0;
    chk("first_latency", 16'(first_vld - first_req), 16'd2);
    chk("stream_pops", seq, 16'd5);

    // consumer stalls: buffer fills, fetch stops, head holds
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    stall_pc = pc_out; stall_cmd = command;
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("stall_req", 16'(imem_req), 16'd0);
    chk("stall_vld", 16'(command_valid), 16'd1);
    chk("stall_pc", pc_out, stall_pc);
    chk("stall_cmd", command, stall_cmd);
    chk("stall_depth", 16'(m_q.size()), 16'd2);
    seq = m_q[0][31:16]; seq_on = 1'b1;
    repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    seq_on = 1'b0;

    // redirect while the request to 0x0005 is in flight
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0);
    mem_lat = 2; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && m_oaddr == 16'h0005 && mem_pend && mem_wait != 0) found = 1'b1;
      else cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    chk("arm_jump", 16'(found), 16'd1);
    xlog.delete(); plog.delete();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
    mem_lat = 0;
    repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("jump_addr", (xlog.size() > 0) ? xlog[0] : 16'hDEAD, 16'h0040);
    chk("jump_pc", (plog.size() > 0) ? plog[0][31:16] : 16'hDEAD, 16'h0040);
    chk("jump_cmd", (plog.size() > 0) ? plog[0][15:0] : 16'hDEAD, mdata(16'h0040));

    // address wrap
    xlog.delete();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("wrap0", (xlog.size() > 2) ? xlog[0] : 16'hDEAD, 16'hFFFF);
    chk("wrap1", (xlog.size() > 2) ? xlog[1] : 16'hDEAD, 16'h0000);
    chk("wrap2", (xlog.size() > 2) ? xlog[2] : 16'hDEAD, 16'h0001);

    // reset pulse with a request outstanding; its data returns after release
    mem_lat = 1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && mem_pend && mem_wait == 1) found = 1'b1;
      else cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    chk("arm_reset", 16'(found), 16'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    plog.delete(); xlog.delete();
    mem_lat = 0;
    repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_first_addr", (xlog.size() > 0) ? xlog[0] : 16'hDEAD, RV);
    chk("rst_first_pc", (plog.size() > 0) ? plog[0][31:16] : 16'hDEAD, RV);
    chk("rst_first_cmd", (plog.size() > 0) ? plog[0][15:0] : 16'hDEAD, mdata(RV));

    // random traffic
    for (int i = 0; i < 500; i++) begin
      mem_lat = $urandom_range(2, 0);
      cycle(($urandom_range(127, 0) != 0), ($urandom_range(3, 0) != 0),
            ($urandom_range(9, 0) < 7), ($urandom_range(11, 0) == 0),
            16'($urandom), ($urandom_range(4, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
